// File: rtl/pb_varint_stream_decoder.sv
// Protobuf base-128 varint stream decoder with optional message-key splitting.
// Optional zigzag (sint) decoding is enabled by defining PB_VARINT_ZIGZAG_EN.
module pb_varint_stream_decoder #(
  parameter int MAX_VARINT_BYTES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        key_mode,
`ifdef PB_VARINT_ZIGZAG_EN
  input  logic        zigzag,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_value,
  output logic [28:0] out_field_number,
  output logic [2:0]  out_wire_type,
  output logic        out_is_key,
  output logic [3:0]  out_nbytes,
  output logic        out_error
);

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state_r;
  logic [3:0]  k_r;
  logic [63:0] acc_r;
  logic        key_r;
`ifdef PB_VARINT_ZIGZAG_EN
  logic        zz_r;
  logic        zz_s;
`endif

  logic        accept_s;
  logic        first_s;
  logic        key_s;
  logic [6:0]  shamt_s;
  logic [63:0] acc_next_s;
  logic        last_s;
  logic        overlong_s;
  logic        key_err_s;
  logic [63:0] value_s;

  // Handshake and next-value datapath; per-varint modes come live from the
  // first byte and from their latched copies afterwards.
  always_comb begin
    in_ready   = !out_valid || out_ready;
    accept_s   = in_valid && in_ready;
    first_s    = (k_r == 4'd0);
    key_s      = first_s ? key_mode : key_r;
    shamt_s    = 7'(k_r) * 7'd7;
    acc_next_s = acc_r | ({57'd0, in_data[6:0]} << shamt_s);
    last_s     = (k_r == 4'(MAX_VARINT_BYTES - 1));
    overlong_s = in_data[7] && last_s;
    key_err_s  = (|acc_next_s[63:32]) || (acc_next_s[2:1] == 2'b11);
`ifdef PB_VARINT_ZIGZAG_EN
    zz_s = first_s ? zigzag : zz_r;
    if (zz_s && !key_s) begin
      value_s = (acc_next_s >> 1) ^ {64{acc_next_s[0]}};
    end else begin
      value_s = acc_next_s;
    end
`else
    value_s = acc_next_s;
`endif
  end

  // Decoder FSM with registered result fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ACCUM;
      k_r              <= 4'd0;
      acc_r            <= 64'd0;
      key_r            <= 1'b0;
`ifdef PB_VARINT_ZIGZAG_EN
      zz_r             <= 1'b0;
`endif
      out_valid        <= 1'b0;
      out_value        <= 64'd0;
      out_field_number <= 29'd0;
      out_wire_type    <= 3'd0;
      out_is_key       <= 1'b0;
      out_nbytes       <= 4'd0;
      out_error        <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept_s) begin
        case (state_r)
          ACCUM: begin
            if (in_data[7] && !last_s) begin
              acc_r <= acc_next_s;
              k_r   <= 4'(k_r + 4'd1);
              if (first_s) begin
                key_r <= key_mode;
`ifdef PB_VARINT_ZIGZAG_EN
                zz_r  <= zigzag;
`endif
              end
            end else begin
              // Terminating byte or over-long varint: emit a result either way.
              out_valid        <= 1'b1;
              out_value        <= value_s;
              out_field_number <= key_s ? value_s[31:3] : 29'd0;
              out_wire_type    <= key_s ? value_s[2:0] : 3'd0;
              out_is_key       <= key_s;
              out_nbytes       <= 4'(k_r + 4'd1);
              out_error        <= overlong_s || (key_s && key_err_s);
              acc_r            <= 64'd0;
              k_r              <= 4'd0;
              if (overlong_s) begin
                state_r <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (!in_data[7]) begin
              state_r <= ACCUM;
            end
          end
          default: begin
            state_r <= ACCUM;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pb_varint_stream_decoder.sv
// Directed bench for pb_varint_stream_decoder: a byte-list reference model
// predicts every result; literal expectations pin the model on key vectors.
module tb_pb_varint_stream_decoder;

  localparam int MAXB = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        key_mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_value;
  logic [28:0] out_field_number;
  logic [2:0]  out_wire_type;
  logic        out_is_key;
  logic [3:0]  out_nbytes;
  logic        out_error;
  logic        zz_in;
`ifdef PB_VARINT_ZIGZAG_EN
  logic        zigzag;
  assign zz_in = zigzag;
`else
  assign zz_in = 1'b0;
`endif

  pb_varint_stream_decoder #(.MAX_VARINT_BYTES(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .key_mode(key_mode),
`ifdef PB_VARINT_ZIGZAG_EN
    .zigzag(zigzag),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_field_number(out_field_number), .out_wire_type(out_wire_type),
    .out_is_key(out_is_key), .out_nbytes(out_nbytes), .out_error(out_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] value;
    logic [3:0]  nbytes;
    logic        err;
    logic        is_key;
  } res_t;

  res_t       exp_q[$];
  logic [7:0] byte_q[$];
  bit         m_key, m_zz, m_drain;

  // Reference model: gather whole varints, then evaluate them arithmetically.
  function automatic void model_byte(input logic [7:0] b, input logic km, input logic zz);
    res_t r;
    logic [63:0] v;
    if (m_drain) begin
      if (!b[7]) m_drain = 1'b0;
      return;
    end
    if (byte_q.size() == 0) begin
      m_key = km;
      m_zz  = zz;
    end
    byte_q.push_back(b);
    if (!b[7] || byte_q.size() == MAXB) begin
      v = 64'd0;
      for (int i = 0; i < byte_q.size(); i++)
        v = v + (64'(byte_q[i][6:0]) << (7 * i));
      r.err = b[7];
      if (m_key && (v > 64'hFFFF_FFFF || (v % 64'd8) >= 64'd6)) r.err = 1'b1;
      if (m_zz && !m_key) v = v[0] ? ~(v >> 1) : (v >> 1);
      r.value  = v;
      r.nbytes = 4'(byte_q.size());
      r.is_key = m_key;
      exp_q.push_back(r);
      if (b[7]) m_drain = 1'b1;
      byte_q.delete();
    end
  endfunction

  int          n_results = 0;
  logic [63:0] last_value;
  logic [28:0] last_field;
  logic [2:0]  last_wire;
  logic        last_key, last_err;
  logic [3:0]  last_nbytes;
  bit          held = 1'b0;
  logic [63:0] held_value;
  logic [3:0]  held_nbytes;
  logic        held_err;

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      byte_q.delete();
      exp_q.delete();
      m_drain = 1'b0;
      held = 1'b0;
    end else begin
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_value", out_value, held_value);
        chk("hold_nbytes", 64'(out_nbytes), 64'(held_nbytes));
        chk("hold_error", 64'(out_error), 64'(held_err));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("value", out_value, e.value);
          chk("nbytes", 64'(out_nbytes), 64'(e.nbytes));
          chk("error", 64'(out_error), 64'(e.err));
          chk("is_key", 64'(out_is_key), 64'(e.is_key));
          chk("field_number", 64'(out_field_number), e.is_key ? 64'(e.value[31:3]) : 64'd0);
          chk("wire_type", 64'(out_wire_type), e.is_key ? 64'(e.value[2:0]) : 64'd0);
        end
        n_results++;
        last_value  = out_value;
        last_field  = out_field_number;
        last_wire   = out_wire_type;
        last_key    = out_is_key;
        last_err    = out_error;
        last_nbytes = out_nbytes;
      end
      held        = out_valid && !out_ready;
      held_value  = out_value;
      held_nbytes = out_nbytes;
      held_err    = out_error;
      if (in_valid && in_ready) model_byte(in_data, key_mode, zz_in);
    end
  end

  task automatic send(input logic [7:0] b, input logic km);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    key_mode = km;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic settle();
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pending_results", 64'(exp_q.size()), 64'd0);
  endtask

  int n0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; key_mode = 1'b0; out_ready = 1'b0;
`ifdef PB_VARINT_ZIGZAG_EN
    zigzag = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_value", out_value, 64'd0);
    chk("rst_out_nbytes", 64'(out_nbytes), 64'd0);
    chk("rst_out_error", 64'(out_error), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // 150 = 0x96 0x01
    send(8'h96, 1'b0); send(8'h01, 1'b0); settle();
    chk("lit_150_value", last_value, 64'd150);
    chk("lit_150_nbytes", 64'(last_nbytes), 64'd2);
    chk("lit_150_error", 64'(last_err), 64'd0);

    // Message keys
    send(8'h1A, 1'b1); settle();
    chk("lit_key_field", 64'(last_field), 64'd3);
    chk("lit_key_wire", 64'(last_wire), 64'd2);
    chk("lit_key_is_key", 64'(last_key), 64'd1);
    chk("lit_key_error", 64'(last_err), 64'd0);
    send(8'h0F, 1'b1); settle();
    chk("lit_wt7_wire", 64'(last_wire), 64'd7);
    chk("lit_wt7_error", 64'(last_err), 64'd1);

    // key_mode only sampled with byte 0: 0x9A 0x01 -> 154, field 19, wire 2
    send(8'h9A, 1'b1); send(8'h01, 1'b0); settle();
    chk("lit_keyhold_is_key", 64'(last_key), 64'd1);
    chk("lit_keyhold_field", 64'(last_field), 64'd19);

    // Key value above 32 bits: 0x80 x4, 0x10 -> 2^32
    for (int i = 0; i < 4; i++) send(8'h80, 1'b1);
    send(8'h10, 1'b1); settle();
    chk("lit_key_big_error", 64'(last_err), 64'd1);

    // Maximum-length all-ones
    for (int i = 0; i < 9; i++) send(8'hFF, 1'b0);
    send(8'h01, 1'b0); settle();
    chk("lit_max_value", last_value, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("lit_max_nbytes", 64'(last_nbytes), 64'd10);
    chk("lit_max_error", 64'(last_err), 64'd0);

    // Over-long varint then drain
    for (int i = 0; i < 10; i++) send(8'h80, 1'b0);
    settle();
    chk("lit_long_error", 64'(last_err), 64'd1);
    chk("lit_long_nbytes", 64'(last_nbytes), 64'd10);
    n0 = n_results;
    send(8'h80, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b0); settle();
    chk("lit_drain_count", 64'(n_results - n0), 64'd1);
    chk("lit_drain_value", last_value, 64'd5);
    chk("lit_drain_error", 64'(last_err), 64'd0);

    // Back-pressure: 0x01 held 3 cycles while 0x02 waits
    n0 = n_results;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h01; key_mode = 1'b0;
    @(posedge clk); #1;
    in_data = 8'h02;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_value", out_value, 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    settle();
    chk("lit_bp_count", 64'(n_results - n0), 64'd2);
    chk("lit_bp_last", last_value, 64'd2);

    // Reset mid-varint discards the partial
    send(8'h96, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h01, 1'b0); settle();
    chk("lit_midrst_value", last_value, 64'd1);
    chk("lit_midrst_nbytes", 64'(last_nbytes), 64'd1);

`ifdef PB_VARINT_ZIGZAG_EN
    zigzag = 1'b1;
    send(8'h03, 1'b0); settle();
    chk("lit_zz_value", last_value, 64'hFFFF_FFFF_FFFF_FFFE);
    zigzag = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
